// File: rtl/calc_input_ctrl.sv
`default_nettype none
// ============================================================================
// calc_input_ctrl : button/switch conditioning and three-state operand entry
//                   for the ALU stage. Optional macro: CALC_INPUT_DEBOUNCE_EN.
// Revision        : 1.0
// ============================================================================
module calc_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic [3:0] sw_value,
    input  logic       sw_operation,
    input  logic       sw_sign,
    output logic [3:0] op1,
    output logic [3:0] op2,
    output logic       operation,
    output logic       sign,
    output logic       result_valid,
    output logic [1:0] entry_state
);

    localparam int unsigned BTN_ENTER = 0;
    localparam int unsigned BTN_CLEAR = 1;

    // Values outside 1..2^20-1 have no meaningful debounce window.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_debounce_cycles
    end

    logic [1:0] btn_meta_q;
    logic [1:0] btn_sync_q;
    logic [3:0] val_meta_q;
    logic [3:0] val_sync_q;
    logic       opsel_meta_q;
    logic       opsel_sync_q;
    logic       sgn_meta_q;
    logic       sgn_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q   <= '0;
            btn_sync_q   <= '0;
            val_meta_q   <= '0;
            val_sync_q   <= '0;
            opsel_meta_q <= 1'b0;
            opsel_sync_q <= 1'b0;
            sgn_meta_q   <= 1'b0;
            sgn_sync_q   <= 1'b0;
        end else begin
            btn_meta_q   <= {btn_clear, btn_enter};
            btn_sync_q   <= btn_meta_q;
            val_meta_q   <= sw_value;
            val_sync_q   <= val_meta_q;
            opsel_meta_q <= sw_operation;
            opsel_sync_q <= opsel_meta_q;
            sgn_meta_q   <= sw_sign;
            sgn_sync_q   <= sgn_meta_q;
        end
    end

    logic [1:0] db;

`ifdef CALC_INPUT_DEBOUNCE_EN
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    for (genvar b = 0; b < 2; b++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             db_q;
        logic             db_d;
        logic             armed_q;
        logic             armed_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q   <= '0;
                db_q    <= 1'b0;
                armed_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                db_q    <= db_d;
                armed_q <= armed_d;
            end
        end

        // Until armed, the counter measures a stable-low stretch, so a button
        // held through reset must be released before it can register again.
        always_comb begin
            cnt_d   = cnt_q;
            db_d    = db_q;
            armed_d = armed_q;
            if (!armed_q) begin
                if (btn_sync_q[b]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    armed_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (btn_sync_q[b] != db_q) begin
                if (cnt_q == CNT_LAST) begin
                    db_d  = btn_sync_q[b];
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end

        assign db[b] = db_q;
    end
`else
    assign db = btn_sync_q;
`endif

    logic [1:0] db_prev_q;
    logic [1:0] press_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            db_prev_q <= '0;
            press_q   <= '0;
        end else begin
            db_prev_q <= db;
            press_q   <= db & ~db_prev_q;
        end
    end

    logic enter_press;
    logic clear_press;
    assign enter_press = press_q[BTN_ENTER];
    assign clear_press = press_q[BTN_CLEAR];

    typedef enum logic [1:0] {
        ST_ENTER_OP1 = 2'b00,
        ST_ENTER_OP2 = 2'b01,
        ST_SHOW      = 2'b10
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic [3:0] op1_q;
    logic [3:0] op1_d;
    logic [3:0] op2_q;
    logic [3:0] op2_d;
    logic       operation_q;
    logic       operation_d;
    logic       sign_q;
    logic       sign_d;
    logic       result_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_ENTER_OP1;
            op1_q          <= '0;
            op2_q          <= '0;
            operation_q    <= 1'b0;
            sign_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            operation_q    <= operation_d;
            sign_q         <= sign_d;
            result_valid_q <= (state_d == ST_SHOW);
        end
    end

    // Clear outranks enter when both pulses land in the same cycle.
    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        operation_d = operation_q;
        sign_d      = sign_q;
        if (clear_press) begin
            state_d     = ST_ENTER_OP1;
            op1_d       = '0;
            op2_d       = '0;
            operation_d = 1'b0;
            sign_d      = 1'b0;
        end else if (enter_press) begin
            case (state_q)
                ST_ENTER_OP1: begin
                    op1_d   = val_sync_q;
                    state_d = ST_ENTER_OP2;
                end
                ST_ENTER_OP2: begin
                    op2_d       = val_sync_q;
                    operation_d = opsel_sync_q;
                    sign_d      = sgn_sync_q;
                    state_d     = ST_SHOW;
                end
                ST_SHOW: begin
                    state_d = ST_ENTER_OP1;
                end
                default: begin
                    state_d = ST_ENTER_OP1;
                end
            endcase
        end
    end

    assign op1          = op1_q;
    assign op2          = op2_q;
    assign operation    = operation_q;
    assign sign         = sign_q;
    assign result_valid = result_valid_q;
    assign entry_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_input_ctrl.sv
`default_nettype none
// ============================================================================
// tb_calc_input_ctrl : self-checking bench for calc_input_ctrl (table vectors,
//                      directed corner sequences, randomized bursts vs model).
// Revision           : 1.0
// ============================================================================
module tb_calc_input_ctrl;

    localparam int unsigned N = 4;
`ifdef CALC_INPUT_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
    localparam int LAT   = N + 3;
`else
    localparam bit DB_EN = 1'b0;
    localparam int LAT   = 3;
`endif

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       btn_enter    = 1'b0;
    logic       btn_clear    = 1'b0;
    logic [3:0] sw_value     = 4'h0;
    logic       sw_operation = 1'b0;
    logic       sw_sign      = 1'b0;
    logic [3:0] op1;
    logic [3:0] op2;
    logic       operation;
    logic       sign;
    logic       result_valid;
    logic [1:0] entry_state;

    always #5 clk = ~clk;

    calc_input_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_enter    (btn_enter),
        .btn_clear    (btn_clear),
        .sw_value     (sw_value),
        .sw_operation (sw_operation),
        .sw_sign      (sw_sign),
        .op1          (op1),
        .op2          (op2),
        .operation    (operation),
        .sign         (sign),
        .result_valid (result_valid),
        .entry_state  (entry_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b,
                                       input logic o, input logic g, input logic v);
        return {19'd0, s, a, b, o, g, v};
    endfunction

    function automatic logic [31:0] dut_pk();
        return pk(entry_state, op1, op2, operation, sign, result_valid);
    endfunction

    // ---------------- reference model ----------------
    // Inputs reach the logic two edges late; a button level flips only after
    // the synced input has disagreed with it for N consecutive edges; a press
    // is the cycle after a rising level. After reset a button must first be
    // seen low for N edges.
    logic [1:0] m_s1, m_s2, m_db, m_dbp, m_pr, m_arm;
    logic [5:0] m_sw1, m_sw2;
    int         m_run [2];
    logic [1:0] m_state;
    logic [3:0] m_op1, m_op2;
    logic       m_opn, m_sign, m_valid;
    bit         m_live = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0; m_pr = '0; m_arm = '0;
            m_sw1 = '0; m_sw2 = '0; m_run[0] = 0; m_run[1] = 0;
            m_state = 2'd0; m_op1 = '0; m_op2 = '0; m_opn = 1'b0; m_sign = 1'b0; m_valid = 1'b0;
            m_live = 1'b1;
        end else begin
            if (m_pr[1]) begin
                m_state = 2'd0; m_op1 = '0; m_op2 = '0; m_opn = 1'b0; m_sign = 1'b0;
            end else if (m_pr[0]) begin
                if (m_state == 2'd0) begin
                    m_op1 = m_sw2[3:0]; m_state = 2'd1;
                end else if (m_state == 2'd1) begin
                    m_op2 = m_sw2[3:0]; m_opn = m_sw2[4]; m_sign = m_sw2[5]; m_state = 2'd2;
                end else begin
                    m_state = 2'd0;
                end
            end
            m_valid = (m_state == 2'd2);
            if (!DB_EN) m_db = m_s2;
            m_pr  = m_db & ~m_dbp;
            m_dbp = m_db;
            if (DB_EN) begin
                for (int b = 0; b < 2; b++) begin
                    if (!m_arm[b]) begin
                        m_run[b] = m_s2[b] ? 0 : m_run[b] + 1;
                        if (m_run[b] == N) begin m_arm[b] = 1'b1; m_run[b] = 0; end
                    end else if (m_s2[b] != m_db[b]) begin
                        m_run[b] = m_run[b] + 1;
                        if (m_run[b] == N) begin m_db[b] = m_s2[b]; m_run[b] = 0; end
                    end else begin
                        m_run[b] = 0;
                    end
                end
            end
            m_s2  = m_s1;
            m_s1  = {btn_clear, btn_enter};
            m_sw2 = m_sw1;
            m_sw1 = {sw_sign, sw_operation, sw_value};
        end
    end

    always @(negedge clk) begin
        if (m_live)
            check("model", dut_pk(), pk(m_state, m_op1, m_op2, m_opn, m_sign, m_valid));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit e, input bit c, input int hold, input int gap);
        btn_enter = e;
        btn_clear = c;
        cycles(hold);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        cycles(gap);
    endtask

    // Raises enter and returns at the negedge after edge k+edges.
    task automatic enter_to_edge(input int edges);
        btn_enter = 1'b1;
        @(posedge clk);
        repeat (edges) @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit          btn;   // 0 = enter, 1 = clear
        logic [3:0]  val;
        logic        opn;
        logic        sgn;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int  trans;
        bit  seen_valid;
        logic [1:0] prev;

        tbl[0] = '{btn: 1'b0, val: 4'h7, opn: 1'b0, sgn: 1'b0, exp: pk(2'd1, 4'h7, 4'h0, 1'b0, 1'b0, 1'b0)};
        tbl[1] = '{btn: 1'b0, val: 4'h2, opn: 1'b0, sgn: 1'b1, exp: pk(2'd2, 4'h7, 4'h2, 1'b0, 1'b1, 1'b1)};
        tbl[2] = '{btn: 1'b0, val: 4'hF, opn: 1'b1, sgn: 1'b1, exp: pk(2'd0, 4'h7, 4'h2, 1'b0, 1'b1, 1'b0)};
        tbl[3] = '{btn: 1'b0, val: 4'hA, opn: 1'b0, sgn: 1'b0, exp: pk(2'd1, 4'hA, 4'h2, 1'b0, 1'b1, 1'b0)};
        tbl[4] = '{btn: 1'b1, val: 4'h0, opn: 1'b0, sgn: 1'b0, exp: pk(2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0)};
        tbl[5] = '{btn: 1'b1, val: 4'h5, opn: 1'b1, sgn: 1'b1, exp: pk(2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0)};
        tbl[6] = '{btn: 1'b0, val: 4'h0, opn: 1'b1, sgn: 1'b1, exp: pk(2'd1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0)};
        tbl[7] = '{btn: 1'b0, val: 4'hF, opn: 1'b1, sgn: 1'b0, exp: pk(2'd2, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1)};
        tbl[8] = '{btn: 1'b1, val: 4'h0, opn: 1'b0, sgn: 1'b0, exp: pk(2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0)};

        // Reset values
        reset = 1'b1;
        cycles(2);
        check("reset_op1", 32'(op1), 32'd0);
        check("reset_op2", 32'(op2), 32'd0);
        check("reset_operation", 32'(operation), 32'd0);
        check("reset_sign", 32'(sign), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_state", 32'(entry_state), 32'd0);
        reset = 1'b0;
        cycles(20);

        // Full entry with latency checks
        sw_value = 4'h5;
        cycles(3);
        enter_to_edge(LAT - 1);
        check("op1_before_update", 32'(op1), 32'd0);
        @(posedge clk); @(negedge clk);
        check("op1_at_update", 32'(op1), 32'h5);
        check("state_after_op1", 32'(entry_state), 32'd1);
        cycles(2);
        btn_enter = 1'b0;
        cycles(10);
        sw_value = 4'h3; sw_operation = 1'b1; sw_sign = 1'b1;
        cycles(3);
        enter_to_edge(LAT - 1);
        check("valid_before_update", 32'(result_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        check("show_fields", dut_pk(), pk(2'd2, 4'h5, 4'h3, 1'b1, 1'b1, 1'b1));
        cycles(2);
        btn_enter = 1'b0;
        cycles(10);

        // Held button from SHOW: exactly one wrap back
        btn_enter = 1'b1;
        trans = 0;
        prev = entry_state;
        repeat (50) begin
            @(negedge clk);
            if (entry_state != prev) trans++;
            prev = entry_state;
        end
        check("held_transitions", 32'(trans), 32'd1);
        check("held_fields", dut_pk(), pk(2'd0, 4'h5, 4'h3, 1'b1, 1'b1, 1'b0));
        btn_enter = 1'b0;
        cycles(10);

        // Glitch: rejected when debouncing, registered otherwise
        press(1'b1, 1'b0, DB_EN ? 3 : 1, 10);
        check("glitch_state", 32'(entry_state), DB_EN ? 32'd0 : 32'd1);
        check("glitch_op1", 32'(op1), DB_EN ? 32'h5 : 32'h3);

        // Clear priority over a simultaneous enter in ENTER_OP2
        press(1'b0, 1'b1, 10, 10);
        check("clear_fields", dut_pk(), pk(2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
        sw_value = 4'h9;
        cycles(3);
        press(1'b1, 1'b0, 10, 10);
        check("op2_entry_state", dut_pk(), pk(2'd1, 4'h9, 4'h0, 1'b0, 1'b0, 1'b0));
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        seen_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (t == 10) begin btn_enter = 1'b0; btn_clear = 1'b0; end
            @(negedge clk);
            if (result_valid) seen_valid = 1'b1;
        end
        check("both_fields", dut_pk(), pk(2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
        check("both_valid_seen", 32'(seen_valid), 32'd0);

        // Table-driven press vectors
        for (int i = 0; i < 9; i++) begin
            sw_value = tbl[i].val; sw_operation = tbl[i].opn; sw_sign = tbl[i].sgn;
            cycles(3);
            press(!tbl[i].btn, tbl[i].btn, 10, 10);
            check($sformatf("table[%0d]", i), dut_pk(), tbl[i].exp);
        end

        // Reset while enter is held: must be released before it counts again
        sw_value = 4'hC;
        btn_enter = 1'b1;
        cycles(3);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(30);
        check("held_through_reset", 32'(entry_state), DB_EN ? 32'd0 : 32'd1);
        btn_enter = 1'b0;
        cycles(10);
        press(1'b1, 1'b0, 10, 10);
        check("press_after_rearm", 32'(entry_state), DB_EN ? 32'd1 : 32'd2);

        // Randomized bursts, checked continuously against the model
        for (int n = 0; n < 150; n++) begin
            int  hold, gap, coff;
            bit  e, c;
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                cycles($urandom_range(1, 2));
                reset = 1'b0;
            end
            e    = ($urandom_range(0, 3) != 0);
            c    = ($urandom_range(0, 5) == 0);
            hold = $urandom_range(1, 12);
            gap  = $urandom_range(1, 12);
            coff = $urandom_range(0, 2);
            for (int t = 0; t < hold + gap; t++) begin
                btn_enter = e && (t < hold);
                btn_clear = c && (t >= coff) && (t < hold);
                if ($urandom_range(0, 3) == 0) begin
                    sw_value     = 4'($urandom);
                    sw_operation = 1'($urandom);
                    sw_sign      = 1'($urandom);
                end
                @(negedge clk);
            end
        end
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
